// File: rtl/mem_access_stage.sv
// Memory-access stage: latches one EX op per handshake, runs loads/stores a byte at a time
// over the 8-bit RAM port and issues registered single-cycle register-file writes.
module mem_access_stage #(
  parameter int ADDR_WIDTH     = 17,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [3:0]                ex_mem_op,
  input  logic [DATA_WIDTH-1:0]     ex_alu_result,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic                      ex_rd_enable,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic                      mem_wr,
  output logic [7:0]                mem_dout,
  input  logic [7:0]                mem_din,
  output logic                      write_enable,
  output logic [REG_ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0]     write_data
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t                    state_reg, state_next;
  logic [2:0]                cnt_reg, cnt_next;
  logic [2:0]                len_reg, len_next;
  logic                      sext_reg, sext_next;
  logic                      rd_en_reg, rd_en_next;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
  logic [DATA_WIDTH-1:0]     store_data_reg, store_data_next;
  logic [2:0][7:0]           lane_reg, lane_next;

  logic [ADDR_WIDTH-1:0]     mem_addr_next;
  logic                      mem_wr_next;
  logic [7:0]                mem_dout_next;
  logic                      write_enable_next;
  logic [REG_ADDR_WIDTH-1:0] write_addr_next;
  logic [DATA_WIDTH-1:0]     write_data_next;

  logic       dec_load, dec_store, dec_sext;
  logic [2:0] dec_len;
  logic [2:0] step;
  logic [DATA_WIDTH-1:0] load_value;
  logic [7:0] store_lane [4];

  assign ex_ready = (state_reg == IDLE) && !rst;
  // step is the index of the edge being processed, counting the accept edge as 0
  assign step = cnt_reg + 3'd1;

  for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
    assign store_lane[gi] = store_data_reg[8*gi +: 8];
  end

  always_comb begin
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_sext  = 1'b0;
    dec_len   = 3'd0;
    case (ex_mem_op)
      4'd1: begin dec_load  = 1'b1; dec_len = 3'd1; dec_sext = 1'b1; end
      4'd2: begin dec_load  = 1'b1; dec_len = 3'd2; dec_sext = 1'b1; end
      4'd3: begin dec_load  = 1'b1; dec_len = 3'd4; end
      4'd4: begin dec_load  = 1'b1; dec_len = 3'd1; end
      4'd5: begin dec_load  = 1'b1; dec_len = 3'd2; end
      4'd6: begin dec_store = 1'b1; dec_len = 3'd1; end
      4'd7: begin dec_store = 1'b1; dec_len = 3'd2; end
      4'd8: begin dec_store = 1'b1; dec_len = 3'd4; end
      default: ;
    endcase
  end

  // The last byte is taken straight from mem_din on the finishing edge.
  always_comb begin
    case (len_reg)
      3'd1:    load_value = {{24{sext_reg & mem_din[7]}}, mem_din};
      3'd2:    load_value = {{16{sext_reg & mem_din[7]}}, mem_din, lane_reg[0]};
      default: load_value = {mem_din, lane_reg[2], lane_reg[1], lane_reg[0]};
    endcase
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    len_next          = len_reg;
    sext_next         = sext_reg;
    rd_en_next        = rd_en_reg;
    rd_addr_next      = rd_addr_reg;
    store_data_next   = store_data_reg;
    lane_next         = lane_reg;
    mem_addr_next     = mem_addr;
    mem_wr_next       = 1'b0;
    mem_dout_next     = mem_dout;
    write_enable_next = 1'b0;
    write_addr_next   = write_addr;
    write_data_next   = write_data;

    case (state_reg)
      IDLE: begin
        if (ex_valid) begin
          cnt_next        = 3'd0;
          len_next        = dec_len;
          sext_next       = dec_sext;
          rd_en_next      = ex_rd_enable;
          rd_addr_next    = ex_rd_addr;
          store_data_next = ex_store_data;
          if (dec_load) begin
            state_next    = LOAD;
            mem_addr_next = ex_alu_result[ADDR_WIDTH-1:0];
          end else if (dec_store) begin
            state_next    = STORE;
            mem_addr_next = ex_alu_result[ADDR_WIDTH-1:0];
            mem_dout_next = ex_store_data[7:0];
            mem_wr_next   = 1'b1;
          end else begin
            write_data_next   = ex_alu_result;
            write_addr_next   = ex_rd_addr;
            write_enable_next = ex_rd_enable && (ex_rd_addr != '0);
          end
        end
      end

      LOAD: begin
        cnt_next = step;
        if (step < len_reg)
          mem_addr_next = mem_addr + ADDR_WIDTH'(1);
        for (int i = 0; i < 3; i++)
          if (step == 3'(i + 2))
            lane_next[i] = mem_din;
        if (step == len_reg + 3'd1) begin
          state_next        = IDLE;
          write_data_next   = load_value;
          write_addr_next   = rd_addr_reg;
          write_enable_next = rd_en_reg && (rd_addr_reg != '0);
        end
      end

      STORE: begin
        cnt_next = step;
        if (step < len_reg) begin
          mem_addr_next = mem_addr + ADDR_WIDTH'(1);
          mem_dout_next = store_lane[step[1:0]];
          mem_wr_next   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      len_reg        <= '0;
      sext_reg       <= 1'b0;
      rd_en_reg      <= 1'b0;
      rd_addr_reg    <= '0;
      store_data_reg <= '0;
      lane_reg       <= '0;
      mem_addr       <= '0;
      mem_wr         <= 1'b0;
      mem_dout       <= '0;
      write_enable   <= 1'b0;
      write_addr     <= '0;
      write_data     <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      len_reg        <= len_next;
      sext_reg       <= sext_next;
      rd_en_reg      <= rd_en_next;
      rd_addr_reg    <= rd_addr_next;
      store_data_reg <= store_data_next;
      lane_reg       <= lane_next;
      mem_addr       <= mem_addr_next;
      mem_wr         <= mem_wr_next;
      mem_dout       <= mem_dout_next;
      write_enable   <= write_enable_next;
      write_addr     <= write_addr_next;
      write_data     <= write_data_next;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: byte RAM with one-cycle read latency, directed cases
// plus a random op stream compared against a byte-array reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        ex_rd_enable;
  logic [4:0]  ex_rd_addr;
  logic [16:0] mem_addr;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ram     [131072];
  logic [7:0] ref_mem [131072];
  logic       sync_req = 1'b0;

  mem_access_stage #(.ADDR_WIDTH(17), .REG_ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_op(ex_mem_op),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd_enable(ex_rd_enable), .ex_rd_addr(ex_rd_addr),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data)
  );

  always #5 clk = ~clk;

  // RAM device; sync_req reloads it from the reference image while the stage is idle
  always @(posedge clk) begin
    if (sync_req)
      ram <= ref_mem;
    else if (mem_wr)
      ram[mem_addr] <= mem_dout;
    mem_din <= ram[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      4'd3, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [16:0] a);
    int          n = nbytes(op);
    logic [31:0] v = 32'd0;
    logic [16:0] ak;
    for (int k = 0; k < n; k++) begin
      ak = a + 17'(k);
      v  = v + (32'(ref_mem[ak]) << (8 * k));
    end
    if ((op == 4'd1 || op == 4'd2) && v >= (32'd1 << (8 * n - 1)))
      v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic sync_ram();
    sync_req = 1'b1;
    @(posedge clk); #1;
    sync_req = 1'b0;
  endtask

  task automatic scramble();
    ex_valid      = 1'b0;
    ex_mem_op     = 4'($urandom);
    ex_alu_result = $urandom;
    ex_store_data = $urandom;
    ex_rd_enable  = 1'($urandom);
    ex_rd_addr    = 5'($urandom);
  endtask

  // Issues one op at the current sample point and follows it until the stage is ready again.
  task automatic run_op(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] sdata,
                        input logic rd_en, input logic [4:0] rd);
    int          n, done_s, w;
    logic        is_ld, is_st, exp_we;
    logic [16:0] a, ak;
    logic [31:0] exp_wd;
    w = 0;
    while (!ex_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!ex_ready) begin
      check_eq("ready_wait", 32'(ex_ready), 32'd1);
      return;
    end
    n      = nbytes(op);
    is_ld  = (op >= 4'd1 && op <= 4'd5);
    is_st  = (op >= 4'd6 && op <= 4'd8);
    a      = alu[16:0];
    exp_we = rd_en && (rd != 5'd0) && !is_st;
    exp_wd = is_ld ? ref_load(op, a) : alu;
    done_s = is_ld ? n + 1 : (is_st ? n : 0);
    if (is_st)
      for (int k = 0; k < n; k++) begin
        ak = a + 17'(k);
        ref_mem[ak] = sdata[8*k +: 8];
      end

    ex_valid = 1'b1; ex_mem_op = op; ex_alu_result = alu;
    ex_store_data = sdata; ex_rd_enable = rd_en; ex_rd_addr = rd;
    @(posedge clk); #1;
    scramble();

    for (int s = 0; s <= done_s; s++) begin
      if (s > 0) begin
        @(posedge clk); #1;
      end
      check_eq("ex_ready", 32'(ex_ready), 32'(s == done_s));
      check_eq("write_enable", 32'(write_enable), 32'(exp_we && s == done_s));
      if (exp_we && s == done_s) begin
        check_eq("write_addr", 32'(write_addr), 32'(rd));
        check_eq("write_data", write_data, exp_wd);
      end
      if ((is_ld || is_st) && s < n) begin
        ak = a + 17'(s);
        check_eq("mem_addr", 32'(mem_addr), 32'(ak));
      end
      if (is_st && s < n) begin
        check_eq("mem_wr_on", 32'(mem_wr), 32'd1);
        check_eq("mem_dout", 32'(mem_dout), 32'(sdata[8*s +: 8]));
      end else begin
        check_eq("mem_wr_off", 32'(mem_wr), 32'd0);
      end
    end
    if (is_st)
      for (int k = 0; k < n; k++) begin
        ak = a + 17'(k);
        check_eq("ram_byte", 32'(ram[ak]), 32'(ref_mem[ak]));
      end
    $display("op=%0d addr/alu=%h sdata=%h rd_en=%0b rd=%0d exp_we=%0b exp_wd=%h busy=%0d",
             op, alu, sdata, rd_en, rd, exp_we, exp_wd, done_s);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] ra;
    for (int i = 0; i < 131072; i++) ref_mem[i] = 8'($urandom);
    rst = 1'b1;
    scramble();
    sync_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sync_req = 1'b0;
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rst_mem_dout", 32'(mem_dout), 32'd0);
    check_eq("rst_write_enable", 32'(write_enable), 32'd0);
    check_eq("rst_write_addr", 32'(write_addr), 32'd0);
    check_eq("rst_write_data", write_data, 32'd0);
    check_eq("rst_ex_ready", 32'(ex_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back NONE ops, second one with rd=0
    run_op(4'd0, 32'h1234_5678, 32'h0, 1'b1, 5'd5);
    run_op(4'd0, 32'hCAFE_0001, 32'h0, 1'b1, 5'd0);

    ref_mem[17'h100] = 8'hEF; ref_mem[17'h101] = 8'hBE;
    ref_mem[17'h102] = 8'hAD; ref_mem[17'h103] = 8'hDE;
    ref_mem[17'h10]  = 8'h80;
    ref_mem[17'h1FFFF] = 8'h34; ref_mem[17'h0] = 8'h12;
    sync_ram();
    run_op(4'd3, 32'h0000_0100, 32'h0, 1'b1, 5'd3);
    check_eq("lw_value", write_data, 32'hDEAD_BEEF);
    run_op(4'd1, 32'h0000_0010, 32'h0, 1'b1, 5'd4);
    check_eq("lb_value", write_data, 32'hFFFF_FF80);
    run_op(4'd4, 32'h0000_0010, 32'h0, 1'b1, 5'd4);
    check_eq("lbu_value", write_data, 32'h0000_0080);
    run_op(4'd2, 32'h0001_FFFF, 32'h0, 1'b1, 5'd9);
    check_eq("lh_wrap_value", write_data, 32'h0000_1234);
    run_op(4'd8, 32'h0000_0200, 32'hA1B2_C3D4, 1'b1, 5'd6);
    run_op(4'd15, 32'h7777_0007, 32'h0, 1'b1, 5'd7);

    // Reset after two bytes of a word store
    ex_valid = 1'b1; ex_mem_op = 4'd8; ex_alu_result = 32'h300;
    ex_store_data = 32'h1122_3344; ex_rd_enable = 1'b0; ex_rd_addr = 5'd0;
    @(posedge clk); #1;
    scramble();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("midrst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("midrst_mem_dout", 32'(mem_dout), 32'd0);
    check_eq("midrst_write_enable", 32'(write_enable), 32'd0);
    check_eq("midrst_write_data", write_data, 32'd0);
    check_eq("midrst_ex_ready", 32'(ex_ready), 32'd0);
    ref_mem[17'h300] = 8'h44;
    ref_mem[17'h301] = 8'h33;
    for (int k = 0; k < 4; k++) begin
      ra = 17'h300 + 17'(k);
      check_eq("midrst_ram", 32'(ram[ra]), 32'(ref_mem[ra]));
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_ready", 32'(ex_ready), 32'd1);
    check_eq("post_rst_mem_wr", 32'(mem_wr), 32'd0);

    for (int t = 0; t < 60; t++) begin
      logic [31:0] alu;
      logic [4:0]  rd;
      alu = $urandom;
      if ($urandom_range(0, 3) == 0)
        alu[16:0] = 17'h1FFFF - 17'($urandom_range(0, 3));
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      run_op(4'($urandom_range(0, 15)), alu, $urandom, 1'($urandom), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access/writeback-feed stage of the naive CPU pipeline. Sits between EX and the register file.
- Takes one EX result per handshake and performs loads and stores byte-serially over the 8-bit RAM port.
- Drives the register file write port (write_enable/write_addr/write_data) with registered, one-cycle write pulses.
- Stalls EX via ex_ready while a multi-byte access is in progress.

Parameters:
- ADDR_WIDTH, 17, width of the RAM byte address.
- REG_ADDR_WIDTH, 5, register index width.
- DATA_WIDTH, 32, word width; fixed at 32, with byte lanes [7:0]..[31:24].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  EX presents an op.
- ex_ready  out  1  stage can accept; ex_ready = (state==IDLE) && !rst.
- ex_mem_op  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 are treated as NONE.
- ex_alu_result  in  32  ALU result (NONE) or byte address (load/store).
- ex_store_data  in  32  rs2 value for stores.
- ex_rd_enable  in  1  op writes rd.
- ex_rd_addr  in  REG_ADDR_WIDTH  destination register.
- mem_addr  out  ADDR_WIDTH  RAM byte address (registered).
- mem_wr  out  1  1 = write mem_dout this cycle (registered).
- mem_dout  out  8  store byte (registered).
- mem_din  in  8  read byte; valid the cycle after its address is presented.
- write_enable  out  1  regfile write strobe (registered, one-cycle pulse).
- write_addr  out  REG_ADDR_WIDTH  regfile write index (registered).
- write_data  out  32  regfile write data (registered).

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; mem_addr, mem_wr, mem_dout, write_enable, write_addr, write_data all 0; ex_ready=0 while rst is high.
  - Reset mid-store leaves the bytes already written in RAM; this is accepted.
- Accept: an op is accepted on a rising edge with ex_valid && ex_ready. Inputs are latched at that edge (E0); EX may change them afterwards.
- Write pulse rule: write_enable is asserted only when rd_enable && rd_addr != 0. Stores never assert write_enable. write_enable defaults to 0 every cycle it is not explicitly pulsed.
- NONE op:
  - At E0: write_data<=ex_alu_result, write_addr<=ex_rd_addr, write_enable per the rule above.
  - State stays IDLE; back-to-back ops are accepted every cycle.
- Load of N bytes (N=1 for LB/LBU, 2 for LH/LHU, 4 for LW):
  - At E0: state->LOAD, mem_addr<=addr, mem_wr<=0, counter k=0.
  - Byte k address is presented in cycle k (between E_k and E_{k+1}). Its data is captured from mem_din at E_{k+2} into lane k (little-endian).
  - Addresses increment by 1 modulo 2^ADDR_WIDTH, so the address wraps; no alignment requirement.
  - At E_{N+1}: write_data<=assembled value, sign-extended (LB/LH) or zero-extended (LBU/LHU); write_enable pulsed; state->IDLE.
  - Occupancy: ex_ready=0 from E0 to E_{N+1}; the next op is accepted at E_{N+2} at the earliest.
- Store of N bytes (SB=1, SH=2, SW=4):
  - At E0: state->STORE, mem_addr<=addr, mem_dout<=store_data[7:0], mem_wr<=1.
  - At E_k for k=1..N-1: mem_addr<=addr+k (wrapping), mem_dout<=lane k.
  - At E_N: mem_wr<=0, state->IDLE. ex_ready returns high in the cycle after E_N.
- Outside STORE, mem_wr=0. mem_addr and mem_dout hold their last values when idle.
- States: IDLE, LOAD, STORE. The counter is 3 bits. An op code outside 0-8 never enters LOAD or STORE.
- No internal flush. EX must not retract an accepted op.

Test Plan:
- Reset during STORE, after 2 of 4 SW bytes -> outputs go to 0 immediately; RAM holds 2 new bytes; after release, ex_ready=1 next cycle.
- NONE, rd=5, result 0x1234_5678, then NONE rd=0 on the next cycle -> write_enable=1, addr 5, data 0x12345678 after E0; second op gives write_enable=0; ex_ready stays 1.
- RAM[0x100..0x103]={0xEF,0xBE,0xAD,0xDE}; LW rd=3 addr 0x100 -> mem_addr 0x100..0x103 on successive cycles; write_data=0xDEADBEEF pulsed at E5; ex_ready low for 5 cycles.
- RAM[0x10]=0x80, LB rd=4 -> 0xFFFF_FF80; LBU -> 0x0000_0080; RAM[0x1FFFF]=0x34, RAM[0x0]=0x12, LH -> 0x0000_1234 (address wrap).
- SW data 0xA1B2C3D4 addr 0x200 -> mem_wr=1 for exactly 4 cycles, bytes D4,C3,B2,A1 at 0x200..0x203; write_enable never set; the next op is accepted at E5.
- Op code 0xF with rd_enable=1, rd=7 -> behaves as NONE: writes ex_alu_result to x7; mem_wr stays 0.
